// File: rtl/fpu_pkg.sv
// Shared FPU definitions: FP32 field layout, rounding-mode codes and the
// decoded-operand record passed between the two halves of the rounder.
package fpu_pkg;

    localparam int unsigned EXP_W    = 8;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned SIG_W    = 24;
    localparam logic [7:0]  EXP_BIAS = 8'd127;
    // First exponent at which every significand bit carries integer weight.
    localparam logic [7:0]  EXP_INT  = 8'd150;
    localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
    localparam int unsigned QNAN_BIT = 22;

    typedef enum logic [1:0] {
        RM_RNE = 2'b00,
        RM_RTZ = 2'b01,
        RM_RDN = 2'b10,
        RM_RUP = 2'b11
    } rmode_t;

    typedef enum logic [2:0] {
        CL_PASS,   // already integral or infinity: pass through
        CL_NAN,    // NaN: quieten
        CL_ZERO,   // zero, or flushed denormal
        CL_FRAC,   // 1 <= |x| < 2^23: fraction bits to discard
        CL_SMALL   // |x| < 1: result is +-0 or +-1
    } fclass_t;

    typedef struct packed {
        logic [31:0]      x;
        rmode_t           rm;
        fclass_t          cls;
        logic [SIG_W-1:0] kept;    // significand with fraction bits cleared
        logic [4:0]       f;       // number of fraction bits
        logic             lsb;
        logic             guard;
        logic             sticky;
    } dec_t;

    function automatic logic round_up(input rmode_t rm, input logic s,
                                      input logic lsb, input logic g,
                                      input logic st);
        logic r;
        case (rm)
            RM_RNE:  r = g & (st | lsb);
            RM_RTZ:  r = 1'b0;
            RM_RDN:  r = s & (g | st);
            default: r = ~s & (g | st);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fround_core.sv
// Combinational FP32 round-to-integral datapath, split into a decode/mask
// half and an increment/normalise half so a register can sit between them.
module fround_core
    import fpu_pkg::*;
#(
    parameter bit FTZ = 1'b1
) (
    input  logic [31:0] x,
    input  logic [1:0]  mode,
    output dec_t        dec,
    input  dec_t        dec_in,
    output logic [31:0] y,
    output logic        inexact
);

    logic [SIG_W-1:0] sig;
    logic [SIG_W-1:0] mask;
    logic [4:0]       fsh;
    logic             inc;
    logic [SIG_W:0]   sum;

    // Decode: classify the operand and split the significand at the binary point.
    always_comb begin
        dec    = '0;
        sig    = {1'b1, x[22:0]};
        fsh    = 5'(EXP_INT - x[30:23]);
        mask   = '0;
        dec.x  = x;
        dec.rm = rmode_t'(mode);
        if (x[30:23] == 8'hFF) begin
            dec.cls = (x[22:0] == '0) ? CL_PASS : CL_NAN;
        end else if (x[30:23] >= EXP_INT) begin
            dec.cls = CL_PASS;
        end else if (x[30:23] == '0 && (x[22:0] == '0 || FTZ)) begin
            dec.cls = CL_ZERO;
        end else if (x[30:23] < EXP_BIAS) begin
            dec.cls    = CL_SMALL;
            dec.guard  = (x[30:23] == EXP_BIAS - 8'd1);
            dec.sticky = dec.guard ? |x[22:0] : 1'b1;
        end else begin
            dec.cls    = CL_FRAC;
            dec.f      = fsh;
            mask       = (24'h1 << fsh) - 24'h1;
            dec.kept   = sig & ~mask;
            dec.lsb    = sig[fsh];
            dec.guard  = sig[fsh - 5'd1];
            dec.sticky = |(sig & (mask >> 1));
        end
    end

    // Increment/normalise: apply the rounding decision and rebuild the FP32 word.
    always_comb begin
        inc     = round_up(dec_in.rm, dec_in.x[31], dec_in.lsb, dec_in.guard, dec_in.sticky);
        sum     = {1'b0, dec_in.kept} + (inc ? (25'h1 << dec_in.f) : 25'h0);
        y       = dec_in.x;
        inexact = 1'b0;
        case (dec_in.cls)
            CL_NAN:  y[QNAN_BIT] = 1'b1;
            CL_ZERO: y = {dec_in.x[31], 31'b0};
            CL_SMALL: begin
                y       = inc ? (FP_ONE | {dec_in.x[31], 31'b0}) : {dec_in.x[31], 31'b0};
                inexact = dec_in.guard | dec_in.sticky;
            end
            CL_FRAC: begin
                // sum[24:23] is 01 without carry, 10 with carry (significand becomes 1.0)
                y       = {dec_in.x[31], dec_in.x[30:23] + {7'b0, sum[24]},
                           sum[23] ? sum[22:0] : 23'b0};
                inexact = dec_in.guard | dec_in.sticky;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/fround_pipe.sv
// Pipelined FP32 round-to-integral unit with valid/ready flow control.
// NSTAGE registers: output always; mid (between core halves) for NSTAGE>=2;
// input for NSTAGE==3. Each stage advances when empty or when the next one does.
module fround_pipe
    import fpu_pkg::*;
#(
    parameter int unsigned NSTAGE = 2,
    parameter bit          FTZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    input  logic [1:0]  mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        inexact
);

    logic [NSTAGE-1:0] vld;
    logic [NSTAGE-1:0] adv;
    logic [NSTAGE-1:0] vin;
    logic [31:0]       core_x;
    logic [1:0]        core_mode;
    dec_t              dec_w;
    dec_t              dec_q;
    logic [31:0]       y_w;
    logic              inx_w;

    // Advance chain from the output back to the input (bubble collapsing).
    always_comb begin
        logic a;
        adv = '0;
        a   = ~vld[NSTAGE-1] | out_ready;
        adv[NSTAGE-1] = a;
        for (int unsigned i = 1; i < NSTAGE; i++) begin
            a = ~vld[NSTAGE-1-i] | a;
            adv[NSTAGE-1-i] = a;
        end
    end

    // Valid bit feeding each stage: the input handshake, then the previous stage.
    always_comb begin
        vin    = '0;
        vin[0] = in_valid;
        for (int unsigned i = 1; i < NSTAGE; i++) begin
            vin[i] = vld[i-1];
        end
    end

    // Stage valid bits; reset flushes every in-flight operand.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld <= '0;
        end else begin
            for (int unsigned i = 0; i < NSTAGE; i++) begin
                if (adv[i]) vld[i] <= vin[i];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[NSTAGE-1];

    if (NSTAGE == 3) begin : g_in
        logic [31:0] x_r;
        logic [1:0]  mode_r;
        // Input operand register.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                x_r    <= '0;
                mode_r <= '0;
            end else if (adv[0]) begin
                x_r    <= x;
                mode_r <= mode;
            end
        end
        assign core_x    = x_r;
        assign core_mode = mode_r;
    end else begin : g_in_bypass
        assign core_x    = x;
        assign core_mode = mode;
    end

    if (NSTAGE >= 2) begin : g_mid
        dec_t dec_r;
        // Register between the decode and increment halves.
        always_ff @(posedge clk) begin
            if (!rstn) begin
                dec_r <= '0;
            end else if (adv[NSTAGE-2]) begin
                dec_r <= dec_w;
            end
        end
        assign dec_q = dec_r;
    end else begin : g_mid_bypass
        assign dec_q = dec_w;
    end

    fround_core #(.FTZ(FTZ)) u_core (
        .x       (core_x),
        .mode    (core_mode),
        .dec     (dec_w),
        .dec_in  (dec_q),
        .y       (y_w),
        .inexact (inx_w)
    );

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            y       <= '0;
            inexact <= 1'b0;
        end else if (adv[NSTAGE-1]) begin
            y       <= y_w;
            inexact <= inx_w;
        end
    end

endmodule

// File: tb/tb_fround_pipe.sv
// Bench for fround_pipe: three instances (NSTAGE 1/2/3, the last with FTZ=0)
// fed the same accepted operand stream; a real-arithmetic model scores every
// result, plus directed vectors, latency, backpressure and reset sequences.
module tb_fround_pipe;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] x = '0;
    logic [1:0]  mode = '0;
    logic        or2 = 1'b1;
    logic        iv13;
    logic        ir1, ir2, ir3, ov1, ov2, ov3, ix1, ix2, ix3;
    logic [31:0] y1, y2, y3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Instances 1 and 3 only see operands that instance 2 accepts.
    assign iv13 = in_valid & ir2;

    fround_pipe #(.NSTAGE(1), .FTZ(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .in_valid(iv13), .in_ready(ir1), .x(x), .mode(mode),
        .out_valid(ov1), .out_ready(1'b1), .y(y1), .inexact(ix1));
    fround_pipe #(.NSTAGE(2), .FTZ(1'b1)) dut2 (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir2), .x(x), .mode(mode),
        .out_valid(ov2), .out_ready(or2), .y(y2), .inexact(ix2));
    fround_pipe #(.NSTAGE(3), .FTZ(1'b0)) dut3 (
        .clk(clk), .rstn(rstn), .in_valid(iv13), .in_ready(ir3), .x(x), .mode(mode),
        .out_valid(ov3), .out_ready(1'b1), .y(y3), .inexact(ix3));

    logic [2:0]  ivv, irv, ovv, orv, ixv;
    logic [31:0] yv [3];
    assign ivv = {iv13, in_valid, iv13};
    assign irv = {ir3, ir2, ir1};
    assign ovv = {ov3, ov2, ov1};
    assign orv = {1'b1, or2, 1'b1};
    assign ixv = {ix3, ix2, ix1};
    assign yv[0] = y1;
    assign yv[1] = y2;
    assign yv[2] = y3;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: exact real-valued rounding of the operand.
    function automatic logic [32:0] ref_round(input logic [31:0] xv, input logic [1:0] mv,
                                              input bit ftz);
        logic        s;
        int unsigned e;
        logic [22:0] m;
        real         a, frac;
        longint      fl, r;
        int          sh, p;
        logic [31:0] yo, ri;
        s = xv[31]; e = xv[30:23]; m = xv[22:0];
        if (e == 255) return {(m == 0) ? xv : (xv | 32'h0040_0000), 1'b0};
        if (e >= 150) return {xv, 1'b0};
        if (e == 0 && (m == 0 || ftz)) return {s, 31'b0, 1'b0};
        a  = real'(m) + ((e == 0) ? 0.0 : 8388608.0);
        sh = (e == 0) ? 149 : 150 - int'(e);
        for (int k = 0; k < sh; k++) a = a / 2.0;
        fl   = longint'($rtoi(a));
        frac = a - real'(fl);
        case (mv)
            2'd0:    r = (frac > 0.5 || (frac == 0.5 && fl[0])) ? fl + 1 : fl;
            2'd1:    r = fl;
            2'd2:    r = (s && frac > 0.0) ? fl + 1 : fl;
            default: r = (!s && frac > 0.0) ? fl + 1 : fl;
        endcase
        if (r == 0) begin
            yo = {s, 31'b0};
        end else begin
            p = 0;
            for (int k = 0; k < 25; k++) if (r[k]) p = k;
            ri = 32'(r << (23 - p));
            yo = {s, 8'(127 + p), ri[22:0]};
        end
        return {yo, frac != 0.0};
    endfunction

    function automatic logic [31:0] rand_x();
        logic [31:0] r;
        int unsigned k;
        r = $urandom;
        k = $urandom_range(0, 9);
        if (k < 6)       r[30:23] = 8'($urandom_range(110, 155));
        else if (k == 6) r[30:23] = 8'hFF;
        else if (k == 7) r[30:23] = 8'h00;
        if ($urandom_range(0, 3) == 0) r[10:0] = 11'h400;
        return r;
    endfunction

    // Scoreboard: expected results per instance, output checks, stall stability.
    logic [32:0] fifo [3][256];
    int unsigned wp [3];
    int unsigned rp [3];
    int unsigned nrecv [3];
    logic [2:0]  pstall = '0;
    logic [31:0] py [3];
    logic [2:0]  pix;
    initial for (int i = 0; i < 3; i++) begin wp[i] = 0; rp[i] = 0; nrecv[i] = 0; end

    always @(negedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 3; i++) rp[i] = wp[i];
            pstall = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                logic [32:0] ex;
                if (pstall[i]) begin
                    check($sformatf("hold_valid%0d", i), 64'(ovv[i]), 64'd1);
                    check($sformatf("hold_y%0d", i), 64'(yv[i]), 64'(py[i]));
                    check($sformatf("hold_inexact%0d", i), 64'(ixv[i]), 64'(pix[i]));
                end
                if (ovv[i] && orv[i]) begin
                    if (rp[i] == wp[i]) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_out%0d: actual y=%h, required no result", i, yv[i]);
                    end else begin
                        ex = fifo[i][rp[i] % 256];
                        rp[i]++;
                        nrecv[i]++;
                        check($sformatf("sb_y%0d", i), 64'(yv[i]), 64'(ex[32:1]));
                        check($sformatf("sb_inexact%0d", i), 64'(ixv[i]), 64'(ex[0]));
                    end
                end
                if (ivv[i] && irv[i]) begin
                    fifo[i][wp[i] % 256] = ref_round(x, mode, i != 2);
                    wp[i]++;
                end
                pstall[i] = ovv[i] & ~orv[i];
                py[i]     = yv[i];
                pix[i]    = ixv[i];
            end
        end
    end

    task automatic send(input logic [31:0] xv, input logic [1:0] mv, output int unsigned waits);
        in_valid = 1'b1; x = xv; mode = mv; waits = 0;
        @(negedge clk);
        while (!ir2 && waits < 100) begin waits++; @(negedge clk); end
        if (!ir2) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: actual in_ready=0, required 1 within 100 cycles");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] x;
        logic [1:0]  mode;
        logic [31:0] y;
        logic        inx;
    } vec_t;
    vec_t tbl [20];

    initial begin
        #500000;
        $display("FAIL global_timeout: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int unsigned w, stalls, n;
        int unsigned base [3];
        logic rnd_done;

        tbl[0]  = '{32'h3FC00000, 2'd0, 32'h40000000, 1'b1};
        tbl[1]  = '{32'h3FC00000, 2'd1, 32'h3F800000, 1'b1};
        tbl[2]  = '{32'h3FC00000, 2'd2, 32'h3F800000, 1'b1};
        tbl[3]  = '{32'h3FC00000, 2'd3, 32'h40000000, 1'b1};
        tbl[4]  = '{32'h40200000, 2'd0, 32'h40000000, 1'b1};
        tbl[5]  = '{32'hC0200000, 2'd0, 32'hC0000000, 1'b1};
        tbl[6]  = '{32'h4AFFFFFF, 2'd0, 32'h4B000000, 1'b1};
        tbl[7]  = '{32'h3F7FFFFF, 2'd3, 32'h3F800000, 1'b1};
        tbl[8]  = '{32'hBE99999A, 2'd2, 32'hBF800000, 1'b1};
        tbl[9]  = '{32'hBE99999A, 2'd1, 32'h80000000, 1'b1};
        tbl[10] = '{32'hBE99999A, 2'd0, 32'h80000000, 1'b1};
        tbl[11] = '{32'hBE99999A, 2'd3, 32'h80000000, 1'b1};
        tbl[12] = '{32'h4B000001, 2'd0, 32'h4B000001, 1'b0};
        tbl[13] = '{32'h7F800000, 2'd2, 32'h7F800000, 1'b0};
        tbl[14] = '{32'h7F800001, 2'd0, 32'h7FC00001, 1'b0};
        tbl[15] = '{32'h00000001, 2'd3, 32'h00000000, 1'b0};
        tbl[16] = '{32'h3F000000, 2'd0, 32'h00000000, 1'b1};
        tbl[17] = '{32'hBF000000, 2'd3, 32'h80000000, 1'b1};
        tbl[18] = '{32'hBF000000, 2'd2, 32'hBF800000, 1'b1};
        tbl[19] = '{32'h3F800000, 2'd0, 32'h3F800000, 1'b0};

        // Reset state
        rstn = 1'b0;
        idle(3);
        check("rst_out_valid", 64'(ovv), 64'd0);
        check("rst_y", 64'(y2), 64'd0);
        check("rst_inexact", 64'(ix2), 64'd0);
        rstn = 1'b1;
        #1;
        check("rst_in_ready", 64'(ir2), 64'd1);

        // Directed vectors on the NSTAGE=2 instance
        for (int i = 0; i < 20; i++) begin
            send(tbl[i].x, tbl[i].mode, w);
            n = 0;
            while (!ov2 && n < 10) begin @(posedge clk); #1; n++; end
            check($sformatf("tbl%0d_valid", i), 64'(ov2), 64'd1);
            check($sformatf("tbl%0d_y", i), 64'(y2), 64'(tbl[i].y));
            check($sformatf("tbl%0d_inexact", i), 64'(ix2), 64'(tbl[i].inx));
        end

        // Latency: out_valid of NSTAGE=k rises exactly k cycles after accept
        idle(5);
        send(rand_x(), 2'($urandom_range(0, 3)), w);
        check("lat_cycle1", 64'(ovv), 64'b001);
        idle(1);
        check("lat_cycle2", 64'(ovv), 64'b010);
        idle(1);
        check("lat_cycle3", 64'(ovv), 64'b100);

        // Full-rate stream
        idle(3);
        for (int i = 0; i < 3; i++) base[i] = nrecv[i];
        stalls = 0;
        for (int i = 0; i < 20; i++) begin
            send(rand_x(), 2'($urandom_range(0, 3)), w);
            stalls += w;
        end
        check("stream_stalls", 64'(stalls), 64'd0);
        idle(3);
        for (int i = 0; i < 3; i++)
            check($sformatf("stream_count%0d", i), 64'(nrecv[i] - base[i]), 64'd20);

        // Backpressure on the NSTAGE=2 instance
        idle(3);
        or2 = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send(rand_x(), 2'($urandom_range(0, 3)), w);
            end
            begin
                int unsigned k, b;
                k = 0;
                @(negedge clk);
                while (!ov2 && k < 20) begin k++; @(negedge clk); end
                check("bp_first_valid", 64'(ov2), 64'd1);
                check("bp_in_ready_full", 64'(ir2), 64'd0);
                idle(3);
                or2 = 1'b1;
                b = nrecv[1];
                idle(6);
                check("bp_no_gap", 64'(nrecv[1] - b), 64'd6);
            end
        join

        // Reset with two operands in flight
        idle(4);
        or2 = 1'b0;
        send(32'h40200000, 2'd0, w);
        send(32'h3FC00000, 2'd3, w);
        base[1] = nrecv[1];
        rstn = 1'b0;
        idle(1);
        rstn = 1'b1;
        check("flush_out_valid", 64'(ov2), 64'd0);
        check("flush_y", 64'(y2), 64'd0);
        check("flush_inexact", 64'(ix2), 64'd0);
        check("flush_in_ready", 64'(ir2), 64'd1);
        or2 = 1'b1;
        idle(5);
        check("flush_no_out", 64'(nrecv[1]), 64'(base[1]));

        // Random operands, random gaps and random consumer stalls
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(rand_x(), 2'($urandom_range(0, 3)), w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    or2 = ($urandom_range(0, 3) != 0);
                end
            end
        join
        or2 = 1'b1;
        idle(10);
        for (int i = 0; i < 3; i++)
            check($sformatf("drain_empty%0d", i), 64'(wp[i] - rp[i]), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
